// File: rtl/piece_motion_ctrl.sv
// Falling-piece position/rotation controller: every move goes through a board
// collision check; handles rotation, hard drop, lock delay and game over.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no piece in play, only spawn accepted
// ST_IDLE  | piece active, one command accepted per cycle
// ST_CHECK | candidate presented on chk_*, chk_req high
module piece_motion_ctrl #(
  parameter int BOARD_W    = 10,
  parameter int BOARD_H    = 20,
  parameter int XW         = 4,
  parameter int YW         = 5,
  parameter int SPAWN_X    = 3,
  parameter int SPAWN_Y    = 0,
  parameter int LOCK_DELAY = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          spawn,
  input  logic          tick,
  input  logic          move_left,
  input  logic          move_right,
  input  logic          move_down,
  input  logic          rotate,
  input  logic          hard_drop,
  output logic          chk_req,
  output logic [XW-1:0] chk_x,
  output logic [YW-1:0] chk_y,
  output logic [1:0]    chk_rot,
  input  logic          chk_done,
  input  logic          chk_ok,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic [1:0]    cur_rot,
  output logic          active,
  output logic          busy,
  output logic          locked,
  output logic          game_over
);

  localparam logic [XW-1:0] X_MAX   = XW'(BOARD_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(BOARD_H - 1);
  localparam logic [XW-1:0] X_SPAWN = XW'(SPAWN_X);
  localparam logic [YW-1:0] Y_SPAWN = YW'(SPAWN_Y);
  localparam int            LCW     = $clog2(LOCK_DELAY + 1);
  localparam logic [LCW-1:0] LOCK_TC = LCW'(LOCK_DELAY);

  typedef enum logic [1:0] {ST_EMPTY, ST_IDLE, ST_CHECK} state_t;
  typedef enum logic [2:0] {K_SPAWN, K_HARD, K_DOWN, K_TICK, K_LEFT, K_RIGHT, K_ROT} kind_t;

  state_t         state_q, state_d;
  kind_t          kind_q, kind_d;
  logic [XW-1:0]  cur_x_q, cur_x_d, chk_x_q, chk_x_d;
  logic [YW-1:0]  cur_y_q, cur_y_d, chk_y_q, chk_y_d;
  logic [1:0]     cur_rot_q, cur_rot_d, chk_rot_q, chk_rot_d;
  logic           chk_req_q, chk_req_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           tick_pend_q, tick_pend_d;
  logic           active_q, active_d;
  logic           locked_q, locked_d;
  logic           game_over_q, game_over_d;

  logic           launch, bump_lock, do_lock;
  kind_t          l_kind;
  logic [XW-1:0]  l_x;
  logic [YW-1:0]  l_y;
  logic [1:0]     l_rot;
  logic [LCW-1:0] lock_inc;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    cur_rot_d   = cur_rot_q;
    chk_x_d     = chk_x_q;
    chk_y_d     = chk_y_q;
    chk_rot_d   = chk_rot_q;
    chk_req_d   = chk_req_q;
    lock_cnt_d  = lock_cnt_q;
    tick_pend_d = tick_pend_q;
    active_d    = active_q;
    locked_d    = 1'b0;
    game_over_d = 1'b0;
    launch      = 1'b0;
    bump_lock   = 1'b0;
    do_lock     = 1'b0;
    l_kind      = K_SPAWN;
    l_x         = cur_x_q;
    l_y         = cur_y_q;
    l_rot       = cur_rot_q;
    lock_inc    = lock_cnt_q + LCW'(1);

    case (state_q)
      ST_EMPTY: begin
        if (spawn) begin
          launch = 1'b1;
          l_kind = K_SPAWN;
          l_x    = X_SPAWN;
          l_y    = Y_SPAWN;
          l_rot  = 2'd0;
        end
      end

      ST_IDLE: begin
        if (spawn) begin
          launch = 1'b1;
          l_kind = K_SPAWN;
          l_x    = X_SPAWN;
          l_y    = Y_SPAWN;
          l_rot  = 2'd0;
        end else if (hard_drop) begin
          if (cur_y_q == Y_MAX) begin
            do_lock = 1'b1;
          end else begin
            launch = 1'b1;
            l_kind = K_HARD;
            l_y    = cur_y_q + YW'(1);
          end
        end else if (rotate) begin
          launch = 1'b1;
          l_kind = K_ROT;
          l_rot  = cur_rot_q + 2'd1;
        end else if (move_left) begin
          if (cur_x_q != '0) begin
            launch = 1'b1;
            l_kind = K_LEFT;
            l_x    = cur_x_q - XW'(1);
          end
        end else if (move_right) begin
          if (cur_x_q != X_MAX) begin
            launch = 1'b1;
            l_kind = K_RIGHT;
            l_x    = cur_x_q + XW'(1);
          end
        end else if (move_down || tick || tick_pend_q) begin
          // a soft drop leaves any pending gravity tick for a later cycle
          if (!move_down) tick_pend_d = 1'b0;
          l_kind = move_down ? K_DOWN : K_TICK;
          if (cur_y_q == Y_MAX) begin
            bump_lock = 1'b1;
          end else begin
            launch = 1'b1;
            l_y    = cur_y_q + YW'(1);
          end
        end
      end

      ST_CHECK: begin
        if (tick) tick_pend_d = 1'b1;
        if (chk_done) begin
          chk_req_d = 1'b0;
          state_d   = ST_IDLE;
          if (chk_ok) begin
            cur_x_d   = chk_x_q;
            cur_y_d   = chk_y_q;
            cur_rot_d = chk_rot_q;
            case (kind_q)
              K_SPAWN: begin
                active_d   = 1'b1;
                lock_cnt_d = '0;
              end
              K_DOWN, K_TICK: lock_cnt_d = '0;
              K_HARD: begin
                lock_cnt_d = '0;
                if (chk_y_q == Y_MAX) begin
                  do_lock = 1'b1;
                end else begin
                  launch = 1'b1;
                  l_kind = K_HARD;
                  l_x    = chk_x_q;
                  l_y    = chk_y_q + YW'(1);
                  l_rot  = chk_rot_q;
                end
              end
              default: ;
            endcase
          end else begin
            case (kind_q)
              K_SPAWN: begin
                game_over_d = 1'b1;
                active_d    = 1'b0;
                state_d     = ST_EMPTY;
              end
              K_HARD:         do_lock   = 1'b1;
              K_DOWN, K_TICK: bump_lock = 1'b1;
              default: ;
            endcase
          end
        end
      end

      default: state_d = ST_EMPTY;
    endcase

    if (bump_lock) begin
      if (lock_inc == LOCK_TC) do_lock = 1'b1;
      else                     lock_cnt_d = lock_inc;
    end

    if (do_lock) begin
      locked_d   = 1'b1;
      active_d   = 1'b0;
      lock_cnt_d = '0;
      state_d    = ST_EMPTY;
    end

    if (launch) begin
      state_d   = ST_CHECK;
      kind_d    = l_kind;
      chk_x_d   = l_x;
      chk_y_d   = l_y;
      chk_rot_d = l_rot;
      chk_req_d = 1'b1;
      if (l_kind == K_SPAWN) begin
        active_d    = 1'b0;
        tick_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      kind_q      <= K_SPAWN;
      cur_x_q     <= X_SPAWN;
      cur_y_q     <= Y_SPAWN;
      cur_rot_q   <= 2'd0;
      chk_x_q     <= X_SPAWN;
      chk_y_q     <= Y_SPAWN;
      chk_rot_q   <= 2'd0;
      chk_req_q   <= 1'b0;
      lock_cnt_q  <= '0;
      tick_pend_q <= 1'b0;
      active_q    <= 1'b0;
      locked_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      cur_rot_q   <= cur_rot_d;
      chk_x_q     <= chk_x_d;
      chk_y_q     <= chk_y_d;
      chk_rot_q   <= chk_rot_d;
      chk_req_q   <= chk_req_d;
      lock_cnt_q  <= lock_cnt_d;
      tick_pend_q <= tick_pend_d;
      active_q    <= active_d;
      locked_q    <= locked_d;
      game_over_q <= game_over_d;
    end
  end

  assign chk_req   = chk_req_q;
  assign chk_x     = chk_x_q;
  assign chk_y     = chk_y_q;
  assign chk_rot   = chk_rot_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign cur_rot   = cur_rot_q;
  assign active    = active_q;
  assign busy      = (state_q == ST_CHECK);
  assign locked    = locked_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Bench for piece_motion_ctrl: a board-model collision checker answers every
// request, and a move-level reference model predicts position and events.
module tb_piece_motion_ctrl;
  localparam int W = 10, H = 20, SX = 3, SY = 0, LD = 2;
  localparam logic [6:0] C_SPAWN = 7'b1000000, C_HARD = 7'b0100000, C_ROT  = 7'b0010000,
                         C_LEFT  = 7'b0001000, C_RIGHT = 7'b0000100, C_DOWN = 7'b0000010,
                         C_TICK  = 7'b0000001;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spawn = 0, tick = 0, move_left = 0, move_right = 0, move_down = 0, rotate = 0, hard_drop = 0;
  logic chk_req, chk_done, chk_ok;
  logic [3:0] chk_x, cur_x;
  logic [4:0] chk_y, cur_y;
  logic [1:0] chk_rot, cur_rot;
  logic active, busy, locked, game_over;

  always #5 clk = ~clk;

  piece_motion_ctrl dut (
    .clk(clk), .reset_n(reset_n), .spawn(spawn), .tick(tick), .move_left(move_left),
    .move_right(move_right), .move_down(move_down), .rotate(rotate), .hard_drop(hard_drop),
    .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_rot(chk_rot),
    .chk_done(chk_done), .chk_ok(chk_ok), .cur_x(cur_x), .cur_y(cur_y), .cur_rot(cur_rot),
    .active(active), .busy(busy), .locked(locked), .game_over(game_over)
  );

  int total = 0, bad = 0;
  bit blk [0:W-1][0:H-1];
  bit rot_bad [0:3];
  int n_req = 0, n_locked = 0, n_gover = 0;
  int last_x, last_y, last_rot, last_after;
  bit chk_en = 1'b1;
  int chk_delay = 0;
  int m_x, m_y, m_rot, m_lock;
  bit m_act;

  function automatic bit free_cell(int x, int y, int r);
    return !blk[x][y] && !rot_bad[r];
  endfunction

  task automatic clear_board();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) blk[x][y] = 1'b0;
    for (int r = 0; r < 4; r++) rot_bad[r] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (locked === 1'b1) n_locked++;
    if (game_over === 1'b1) n_gover++;
  end

  // board-side checker: answers each request after a short delay
  initial begin
    int d, cx, cy, cr;
    chk_done = 1'b0;
    chk_ok   = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en && reset_n === 1'b1 && chk_req === 1'b1) begin
        cx = int'(chk_x); cy = int'(chk_y); cr = int'(chk_rot);
        n_req++;
        d = (chk_delay > 0) ? chk_delay : int'($urandom_range(1, 3));
        repeat (d) begin
          @(negedge clk);
          total++;
          if (chk_req !== 1'b1 || int'(chk_x) != cx || int'(chk_y) != cy || int'(chk_rot) != cr) begin
            bad++;
            $display("FAIL cand_stable: req=%0b x=%0d y=%0d rot=%0d, want req=1 x=%0d y=%0d rot=%0d",
                     chk_req, chk_x, chk_y, chk_rot, cx, cy, cr);
          end
        end
        chk_ok   = free_cell(cx, cy, cr);
        chk_done = 1'b1;
        last_x = cx; last_y = cy; last_rot = cr;
        @(negedge clk);
        chk_done   = 1'b0;
        chk_ok     = 1'b0;
        last_after = int'(chk_req);
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic [6:0] m);
    @(negedge clk);
    {spawn, hard_drop, rotate, move_left, move_right, move_down, tick} = m;
    @(negedge clk);
    {spawn, hard_drop, rotate, move_left, move_right, move_down, tick} = '0;
    for (int i = 0; i < 400 && busy === 1'b1; i++) @(negedge clk);
    if (busy !== 1'b0) begin
      $display("FAIL cmd_timeout: busy=%0b want 0", busy);
      $fatal(1, "command never completed");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (cur_x !== 4'd3 || cur_y !== 5'd0 || cur_rot !== 2'd0) begin
      bad++; $display("FAIL reset_cur: got (%0d,%0d,%0d) want (3,0,0)", cur_x, cur_y, cur_rot);
    end
    total++;
    if ({chk_req, active, busy, locked, game_over} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: req/act/busy/lock/go=%b want 00000",
                      {chk_req, active, busy, locked, game_over});
    end
  endtask

  task automatic test_spawn();
    int r0;
    clear_board();
    r0 = n_req;
    do_cmd(C_SPAWN);
    total++;
    if (active !== 1'b1 || cur_x !== 4'd3 || cur_y !== 5'd0 || cur_rot !== 2'd0) begin
      bad++; $display("FAIL spawn_ok: act=%0b cur=(%0d,%0d,%0d) want act=1 (3,0,0)", active, cur_x, cur_y, cur_rot);
    end
    total++;
    if (n_req - r0 != 1 || last_x != 3 || last_y != 0 || last_rot != 0 || last_after != 0) begin
      bad++; $display("FAIL spawn_req: n=%0d cand=(%0d,%0d,%0d) req_after=%0d want n=1 (3,0,0) 0",
                      n_req - r0, last_x, last_y, last_rot, last_after);
    end
  endtask

  task automatic test_bounds();
    int r0;
    r0 = n_req;
    repeat (3) do_cmd(C_LEFT);
    total++;
    if (cur_x !== 4'd0 || n_req - r0 != 3) begin
      bad++; $display("FAIL left_walk: x=%0d reqs=%0d want x=0 reqs=3", cur_x, n_req - r0);
    end
    r0 = n_req;
    do_cmd(C_LEFT);
    total++;
    if (cur_x !== 4'd0 || n_req - r0 != 0) begin
      bad++; $display("FAIL left_edge: x=%0d reqs=%0d want x=0 reqs=0", cur_x, n_req - r0);
    end
    repeat (9) do_cmd(C_RIGHT);
    r0 = n_req;
    do_cmd(C_RIGHT);
    total++;
    if (cur_x !== 4'd9 || n_req - r0 != 0) begin
      bad++; $display("FAIL right_edge: x=%0d reqs=%0d want x=9 reqs=0", cur_x, n_req - r0);
    end
  endtask

  task automatic test_lock();
    int l0;
    clear_board();
    do_cmd(C_SPAWN);
    l0 = n_locked;
    blk[3][1] = 1'b1;
    do_cmd(C_TICK);
    total++;
    if (active !== 1'b1 || cur_y !== 5'd0 || n_locked != l0) begin
      bad++; $display("FAIL lock_first: act=%0b y=%0d locks=%0d want act=1 y=0 locks=0", active, cur_y, n_locked - l0);
    end
    blk[3][1] = 1'b0;
    do_cmd(C_TICK);
    blk[3][2] = 1'b1;
    do_cmd(C_DOWN);
    total++;
    if (active !== 1'b1 || cur_y !== 5'd1 || n_locked != l0) begin
      bad++; $display("FAIL lock_reset_cnt: act=%0b y=%0d locks=%0d want act=1 y=1 locks=0", active, cur_y, n_locked - l0);
    end
    do_cmd(C_TICK);
    total++;
    if (active !== 1'b0 || cur_y !== 5'd1 || n_locked - l0 != 1) begin
      bad++; $display("FAIL lock_second: act=%0b y=%0d locks=%0d want act=0 y=1 locks=1", active, cur_y, n_locked - l0);
    end
  endtask

  task automatic test_hard_drop();
    int r0, l0, gaps;
    bit seen;
    clear_board();
    do_cmd(C_SPAWN);
    blk[3][8] = 1'b1;
    r0 = n_req; l0 = n_locked; gaps = 0; seen = 1'b0;
    @(negedge clk);
    hard_drop = 1'b1;
    @(negedge clk);
    hard_drop = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (locked === 1'b1) begin seen = 1'b1; break; end
      if (busy !== 1'b1) gaps++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    total++;
    if (!seen || gaps != 0) begin
      bad++; $display("FAIL hard_flow: locked_seen=%0b idle_gaps=%0d want 1 0", seen, gaps);
    end
    total++;
    if (cur_y !== 5'd7 || n_req - r0 != 8 || n_locked - l0 != 1 || active !== 1'b0) begin
      bad++; $display("FAIL hard_result: y=%0d reqs=%0d locks=%0d act=%0b want 7 8 1 0",
                      cur_y, n_req - r0, n_locked - l0, active);
    end
    clear_board();
    do_cmd(C_SPAWN);
    r0 = n_req; l0 = n_locked;
    do_cmd(C_HARD);
    total++;
    if (cur_y !== 5'd19 || n_req - r0 != 19 || n_locked - l0 != 1) begin
      bad++; $display("FAIL hard_floor: y=%0d reqs=%0d locks=%0d want 19 19 1", cur_y, n_req - r0, n_locked - l0);
    end
  endtask

  task automatic test_rotate();
    int r0;
    clear_board();
    do_cmd(C_SPAWN);
    repeat (3) do_cmd(C_ROT);
    total++;
    if (cur_rot !== 2'd3) begin
      bad++; $display("FAIL rot_three: rot=%0d want 3", cur_rot);
    end
    do_cmd(C_ROT);
    total++;
    if (cur_rot !== 2'd0) begin
      bad++; $display("FAIL rot_wrap: rot=%0d want 0", cur_rot);
    end
    rot_bad[1] = 1'b1;
    r0 = n_req;
    do_cmd(C_ROT);
    total++;
    if (cur_rot !== 2'd0 || n_req - r0 != 1 || active !== 1'b1) begin
      bad++; $display("FAIL rot_blocked: rot=%0d reqs=%0d act=%0b want 0 1 1", cur_rot, n_req - r0, active);
    end
    rot_bad[1] = 1'b0;
  endtask

  task automatic test_priority();
    int r0, l0;
    r0 = n_req;
    do_cmd(C_LEFT | C_RIGHT | C_TICK);
    total++;
    if (cur_x !== 4'd2 || cur_y !== 5'd0 || n_req - r0 != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL prio_left: x=%0d y=%0d reqs=%0d busy=%0b want 2 0 1 0", cur_x, cur_y, n_req - r0, busy);
    end
    r0 = n_req;
    do_cmd(C_ROT | C_LEFT | C_DOWN);
    total++;
    if (cur_rot !== 2'd1 || cur_x !== 4'd2 || cur_y !== 5'd0 || n_req - r0 != 1) begin
      bad++; $display("FAIL prio_rot: rot=%0d x=%0d y=%0d reqs=%0d want 1 2 0 1", cur_rot, cur_x, cur_y, n_req - r0);
    end
    do_cmd(C_DOWN);
    do_cmd(C_DOWN);
    l0 = n_locked;
    do_cmd(C_SPAWN | C_HARD);
    total++;
    if ({cur_x, cur_y, cur_rot} !== {4'd3, 5'd0, 2'd0} || n_locked != l0 || active !== 1'b1) begin
      bad++; $display("FAIL prio_spawn: cur=(%0d,%0d,%0d) locks=%0d act=%0b want (3,0,0) 0 1",
                      cur_x, cur_y, cur_rot, n_locked - l0, active);
    end
  endtask

  task automatic test_tick_pend();
    int r0;
    chk_delay = 3;
    r0 = n_req;
    @(negedge clk); rotate = 1'b1;
    @(negedge clk); rotate = 1'b0; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    for (int i = 0; i < 200 && !(n_req - r0 >= 2 && busy === 1'b0); i++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk_delay = 0;
    total++;
    if (n_req - r0 != 2 || cur_rot !== 2'd1 || cur_y !== 5'd1) begin
      bad++; $display("FAIL tick_pend: reqs=%0d rot=%0d y=%0d want 2 1 1", n_req - r0, cur_rot, cur_y);
    end
  endtask

  task automatic test_game_over();
    int g0, r0;
    blk[3][0] = 1'b1;
    g0 = n_gover;
    do_cmd(C_SPAWN);
    total++;
    if (n_gover - g0 != 1 || active !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL game_over: pulses=%0d act=%0b busy=%0b want 1 0 0", n_gover - g0, active, busy);
    end
    r0 = n_req;
    do_cmd(C_LEFT);
    do_cmd(C_TICK);
    total++;
    if (n_req - r0 != 0) begin
      bad++; $display("FAIL empty_discard: reqs=%0d want 0", n_req - r0);
    end
    clear_board();
  endtask

  task automatic test_reset_mid_check();
    do_cmd(C_SPAWN);
    do_cmd(C_RIGHT);
    chk_en = 1'b0;
    @(negedge clk); rotate = 1'b1;
    @(negedge clk); rotate = 1'b0;
    total++;
    if (chk_req !== 1'b1 || cur_x !== 4'd4) begin
      bad++; $display("FAIL pre_reset: req=%0b x=%0d want 1 4", chk_req, cur_x);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (chk_req !== 1'b0 || busy !== 1'b0 || active !== 1'b0 ||
        {cur_x, cur_y, cur_rot} !== {4'd3, 5'd0, 2'd0}) begin
      bad++; $display("FAIL async_reset: req=%0b busy=%0b act=%0b cur=(%0d,%0d,%0d) want 0 0 0 (3,0,0)",
                      chk_req, busy, active, cur_x, cur_y, cur_rot);
    end
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(negedge clk);
  endtask

  task automatic model_cmd(input int c, output int er, output int el, output int eg);
    int nr;
    bit ok;
    er = 0; el = 0; eg = 0; ok = 1'b0;
    case (c)
      0: if (m_x > 0) begin er = 1; if (free_cell(m_x - 1, m_y, m_rot)) m_x--; end
      1: if (m_x < W - 1) begin er = 1; if (free_cell(m_x + 1, m_y, m_rot)) m_x++; end
      2, 3: begin
        if (m_y < H - 1) begin
          er = 1;
          if (free_cell(m_x, m_y + 1, m_rot)) begin m_y++; m_lock = 0; ok = 1'b1; end
        end
        if (!ok) begin
          m_lock++;
          if (m_lock >= LD) begin el = 1; m_act = 1'b0; m_lock = 0; end
        end
      end
      4: begin
        er = 1;
        nr = (m_rot + 1) % 4;
        if (free_cell(m_x, m_y, nr)) m_rot = nr;
      end
      5: begin
        while (m_y < H - 1 && free_cell(m_x, m_y + 1, m_rot)) begin er++; m_y++; end
        if (m_y < H - 1) er++;
        el = 1; m_act = 1'b0; m_lock = 0;
      end
      default: begin
        er = 1;
        if (free_cell(SX, SY, 0)) begin
          m_x = SX; m_y = SY; m_rot = 0; m_act = 1'b1; m_lock = 0;
        end else begin
          eg = 1; m_act = 1'b0;
        end
      end
    endcase
  endtask

  task automatic test_random();
    int c, r, er, el, eg, r0, l0, g0;
    logic [6:0] masks [0:6];
    masks[0] = C_LEFT; masks[1] = C_RIGHT; masks[2] = C_DOWN; masks[3] = C_TICK;
    masks[4] = C_ROT;  masks[5] = C_HARD;  masks[6] = C_SPAWN;
    do_reset();
    clear_board();
    m_x = SX; m_y = SY; m_rot = 0; m_lock = 0; m_act = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!m_act) begin
        c = 6;
      end else begin
        r = int'($urandom_range(0, 19));
        c = (r < 4) ? 0 : (r < 8) ? 1 : (r < 11) ? 2 : (r < 14) ? 3 : (r < 17) ? 4 : (r < 19) ? 5 : 6;
      end
      if (c == 6) begin
        for (int x = 0; x < W; x++)
          for (int y = 1; y < H; y++) blk[x][y] = ($urandom_range(0, 99) < 12);
        for (int k = 1; k < 4; k++) rot_bad[k] = ($urandom_range(0, 99) < 20);
      end
      r0 = n_req; l0 = n_locked; g0 = n_gover;
      model_cmd(c, er, el, eg);
      do_cmd(masks[c]);
      total++;
      if (int'(cur_x) != m_x || int'(cur_y) != m_y || int'(cur_rot) != m_rot || active !== m_act) begin
        bad++; $display("FAIL rand_pos[%0d] cmd=%0d: cur=(%0d,%0d,%0d) act=%0b want (%0d,%0d,%0d) act=%0b",
                        i, c, cur_x, cur_y, cur_rot, active, m_x, m_y, m_rot, m_act);
      end
      total++;
      if (n_req - r0 != er || n_locked - l0 != el || n_gover - g0 != eg) begin
        bad++; $display("FAIL rand_evt[%0d] cmd=%0d: reqs=%0d locks=%0d go=%0d want %0d %0d %0d",
                        i, c, n_req - r0, n_locked - l0, n_gover - g0, er, el, eg);
      end
    end
  endtask

  initial begin
    clear_board();
    test_reset();
    test_spawn();
    test_bounds();
    test_lock();
    test_hard_drop();
    test_rotate();
    test_priority();
    test_tick_pend();
    test_game_over();
    test_reset_mid_check();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
